// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit positive-edge register with asynchronous
// clear/preset, clock enable, parallel load, logical and arithmetic shifts,
// rotates, a registered carry-out and a tri-state bus output. Intended as the
// SAP accumulator/temp register that executes shift and rotate instructions.
module univ_shift_reg #(
  parameter int          WIDTH       = 8,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             preset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  input  logic             oe,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] bus_out,
  output logic             cout,
  output logic             zero
);

  // Synchronous clear value, truncated to the register width.
  localparam logic [WIDTH-1:0] SYNC_CLEAR_Q = RESET_VALUE[WIDTH-1:0];

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_ASR  = 3'b110,
    MODE_CLR  = 3'b111
  } mode_t;

  logic [WIDTH-1:0] q_next;
  logic             cout_next;
  mode_t            op;

  assign op = mode_t'(mode);

  // Next-state decode; sin is only looked at by the two logical shifts so it
  // cannot leak X into rotates or the arithmetic shift.
  always_comb begin
    q_next    = q;
    cout_next = cout;
    unique case (op)
      MODE_HOLD: begin
        q_next    = q;
        cout_next = cout;
      end
      MODE_LOAD: begin
        q_next    = d;
      end
      MODE_SHL: begin
        q_next    = {q[WIDTH-2:0], sin};
        cout_next = q[WIDTH-1];
      end
      MODE_SHR: begin
        q_next    = {sin, q[WIDTH-1:1]};
        cout_next = q[0];
      end
      MODE_ROL: begin
        q_next    = {q[WIDTH-2:0], q[WIDTH-1]};
        cout_next = q[WIDTH-1];
      end
      MODE_ROR: begin
        q_next    = {q[0], q[WIDTH-1:1]};
        cout_next = q[0];
      end
      MODE_ASR: begin
        q_next    = {q[WIDTH-1], q[WIDTH-1:1]};
        cout_next = q[0];
      end
      MODE_CLR: begin
        q_next    = SYNC_CLEAR_Q;
        cout_next = 1'b0;
      end
      default: begin
        q_next    = q;
        cout_next = cout;
      end
    endcase
  end

  // State register: clear beats preset, and while either is low edges are ignored.
  always_ff @(posedge clk or negedge clear or negedge preset) begin
    if (!clear) begin
      q    <= '0;
      cout <= 1'b0;
    end else if (!preset) begin
      q    <= '1;
      cout <= 1'b0;
    end else if (en) begin
      q    <= q_next;
      cout <= cout_next;
    end
  end

  assign qbar    = ~q;
  assign zero    = (q == '0);
  assign bus_out = oe ? q : 'z;

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed bench for univ_shift_reg (WIDTH=8) using a
// table of hand-computed vectors plus short sequences for the async corners.
module tb_univ_shift_reg;

  logic       clk;
  logic       clear;
  logic       preset;
  logic       en;
  logic [2:0] mode;
  logic [7:0] d;
  logic       sin;
  logic       oe;
  logic [7:0] q;
  logic [7:0] qbar;
  wire  [7:0] bus_out;
  logic       cout;
  logic       zero;

  int checks;
  int errors;

  typedef struct {
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sin;
    logic [7:0] exp_q;
    logic       exp_cout;
  } vec_t;

  vec_t vecs[$];

  univ_shift_reg #(.WIDTH(8), .RESET_VALUE(0)) dut (
    .clk     (clk),
    .clear   (clear),
    .preset  (preset),
    .en      (en),
    .mode    (mode),
    .d       (d),
    .sin     (sin),
    .oe      (oe),
    .q       (q),
    .qbar    (qbar),
    .bus_out (bus_out),
    .cout    (cout),
    .zero    (zero)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare every register-derived output against one expected q/cout pair.
  task automatic check_state(input string name, input logic [7:0] exp_q, input logic exp_cout);
    check_value({name, ".q"}, q, exp_q);
    check_value({name, ".cout"}, {7'd0, cout}, {7'd0, exp_cout});
    check_value({name, ".qbar"}, qbar, ~exp_q);
    check_value({name, ".zero"}, {7'd0, zero}, {7'd0, (exp_q == 8'h00)});
  endtask

  task automatic add_vec(input logic e, input logic [2:0] m, input logic [7:0] dv,
                         input logic s, input logic [7:0] eq, input logic ec);
    vec_t v;
    v.en = e; v.mode = m; v.d = dv; v.sin = s; v.exp_q = eq; v.exp_cout = ec;
    vecs.push_back(v);
  endtask

  // Drive inputs on the falling edge, let one rising edge happen, sample after it.
  task automatic apply_stimulus(input vec_t v);
    @(negedge clk);
    en   = v.en;
    mode = v.mode;
    d    = v.d;
    sin  = v.sin;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Both asynchronous inputs low from time zero, load requested.
    clear  = 1'b0;
    preset = 1'b0;
    en     = 1'b1;
    mode   = 3'b001;
    d      = 8'hA5;
    sin    = 1'b0;
    oe     = 1'b0;
    #1;
    check_state("reset", 8'h00, 1'b0);

    // Clock edges while held in clear/preset are ignored.
    repeat (3) @(posedge clk);
    #1;
    check_state("reset_edges", 8'h00, 1'b0);

    // Release both between edges: nothing happens until the next edge.
    @(negedge clk);
    clear  = 1'b1;
    preset = 1'b1;
    #1;
    check_state("release", 8'h00, 1'b0);
    @(posedge clk);
    #1;
    check_state("first_load", 8'hA5, 1'b0);

    // Preset alone, mid-cycle with no clock edge.
    @(negedge clk);
    #2;
    preset = 1'b0;
    #1;
    check_state("preset_async", 8'hFF, 1'b0);
    @(posedge clk);
    #1;
    check_state("preset_edge", 8'hFF, 1'b0);
    @(negedge clk);
    preset = 1'b1;
    mode   = 3'b000;
    @(posedge clk);
    #1;
    check_state("preset_hold", 8'hFF, 1'b0);

    // Directed vector table: en, mode, d, sin, expected q, expected cout.
    add_vec(1'b1, 3'b001, 8'h81, 1'b0, 8'h81, 1'b0);
    add_vec(1'b1, 3'b010, 8'h00, 1'b0, 8'h02, 1'b1);
    add_vec(1'b1, 3'b011, 8'h00, 1'b1, 8'h81, 1'b0);
    add_vec(1'b1, 3'b001, 8'h96, 1'b0, 8'h96, 1'b0);
    add_vec(1'b1, 3'b100, 8'h00, 1'b1, 8'h2D, 1'b1);
    add_vec(1'b1, 3'b100, 8'h00, 1'b1, 8'h5A, 1'b0);
    add_vec(1'b1, 3'b100, 8'h00, 1'b1, 8'hB4, 1'b0);
    add_vec(1'b1, 3'b100, 8'h00, 1'b1, 8'h69, 1'b1);
    add_vec(1'b1, 3'b100, 8'h00, 1'b1, 8'hD2, 1'b0);
    add_vec(1'b1, 3'b100, 8'h00, 1'b1, 8'hA5, 1'b1);
    add_vec(1'b1, 3'b100, 8'h00, 1'b1, 8'h4B, 1'b1);
    add_vec(1'b1, 3'b100, 8'h00, 1'b1, 8'h96, 1'b0);
    add_vec(1'b1, 3'b001, 8'h90, 1'b0, 8'h90, 1'b0);
    add_vec(1'b1, 3'b110, 8'h00, 1'b0, 8'hC8, 1'b0);
    add_vec(1'b0, 3'b111, 8'h00, 1'b0, 8'hC8, 1'b0);
    add_vec(1'b1, 3'b111, 8'h00, 1'b0, 8'h00, 1'b0);
    add_vec(1'b1, 3'b001, 8'h3C, 1'b0, 8'h3C, 1'b0);
    add_vec(1'b1, 3'b101, 8'h00, 1'b0, 8'h1E, 1'b0);
    add_vec(1'b1, 3'b101, 8'h00, 1'b0, 8'h0F, 1'b0);
    add_vec(1'b1, 3'b101, 8'h00, 1'b0, 8'h87, 1'b1);
    add_vec(1'b1, 3'b001, 8'h55, 1'b0, 8'h55, 1'b1);
    add_vec(1'b1, 3'b000, 8'hFF, 1'b1, 8'h55, 1'b1);
    add_vec(1'b1, 3'b110, 8'h00, 1'b0, 8'h2A, 1'b1);
    add_vec(1'b1, 3'b011, 8'h00, 1'b0, 8'h15, 1'b0);
    add_vec(1'b1, 3'b010, 8'h00, 1'b1, 8'h2B, 1'b0);
    add_vec(1'b0, 3'b010, 8'h00, 1'b1, 8'h2B, 1'b0);
    add_vec(1'b0, 3'b001, 8'hEE, 1'b0, 8'h2B, 1'b0);
    add_vec(1'b1, 3'b001, 8'h3C, 1'b0, 8'h3C, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      check_state($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_cout);
    end

    // Bus output: released while oe=0, carries q while oe=1.
    @(negedge clk);
    en = 1'b0;
    oe = 1'b0;
    #1;
    checks++;
    if (bus_out === 8'h3C) begin
      errors++;
      $display("[TB] FAIL bus_released: got %h expected zz", bus_out);
    end
    oe = 1'b1;
    #1;
    check_value("bus_driven", bus_out, 8'h3C);
    check_value("bus_qbar", qbar, 8'hC3);

    // Shift a one into cout, then clear asynchronously mid-cycle.
    @(negedge clk);
    en   = 1'b1;
    mode = 3'b100;
    d    = 8'h00;
    @(posedge clk);
    #1;
    check_state("pre_clear_rol", 8'h78, 1'b0);
    @(negedge clk);
    mode = 3'b001;
    d    = 8'h80;
    @(posedge clk);
    #1;
    @(negedge clk);
    mode = 3'b010;
    @(posedge clk);
    #1;
    check_state("pre_clear_shl", 8'h00, 1'b1);
    @(negedge clk);
    mode = 3'b001;
    d    = 8'h7E;
    @(posedge clk);
    #1;
    check_state("pre_clear_load", 8'h7E, 1'b1);
    @(negedge clk);
    #2;
    clear = 1'b0;
    #1;
    check_state("clear_async", 8'h00, 1'b0);
    check_value("bus_cleared", bus_out, 8'h00);
    @(negedge clk);
    clear = 1'b1;
    en    = 1'b0;
    #20;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised successor to the single-bit edge-triggered flip-flop: a WIDTH-bit positive-edge register.
- Keeps the asynchronous preset/clear pair.
- Adds clock enable, parallel load, logical/arithmetic shifts, rotates and a registered carry-out.
- Drives a tri-state bus output; intended as the SAP accumulator/temp register that executes shift and rotate instructions.

Parameters:
- WIDTH, 8, register width in bits; legal range 2 to 32.
- RESET_VALUE, 0, value loaded into q by synchronous clear mode (mode 111).

Ports:
- clk  input  1  system clock; all synchronous updates occur on its rising edge.
- clear  input  1  asynchronous active-low reset; forces q to all zeros and cout to 0.
- preset  input  1  asynchronous active-low preset; forces q to all ones and cout to 0.
- en  input  1  clock enable; when 0, q and cout hold regardless of mode.
- mode  input  3  operation select, decoded below.
- d  input  WIDTH  parallel load data.
- sin  input  1  serial input for logical shifts.
- oe  input  1  bus output enable.
- q  output  WIDTH  register contents.
- qbar  output  WIDTH  bitwise inverse of q, combinational.
- bus_out  output  WIDTH  equals q when oe=1, high-impedance on all bits when oe=0.
- cout  output  1  registered bit shifted or rotated out by the last shift/rotate op.
- zero  output  1  combinational flag, 1 when q == 0.

Behaviour:
- Async priority: clear low dominates preset low. Both low -> q=0, cout=0.
- preset low alone -> q = all ones, cout=0.
- Either asynchronous input asserted -> outputs change immediately without a clock edge, and clock edges are ignored.
- Release of clear/preset takes effect at the next rising edge with en=1. No synchronous action occurs on the release itself.
- Reset values: q=0, qbar=all ones, cout=0, zero=1, bus_out=Z when oe=0.
- Synchronous ops occur on the rising clk edge with en=1 and both async inputs high. Latency 1 cycle: q reflects the op immediately after the edge.
- mode 000 hold: q and cout unchanged.
- mode 001 load: q<=d; cout unchanged.
- mode 010 shift left: q<={q[WIDTH-2:0],sin}; cout<=q[WIDTH-1].
- mode 011 shift right: q<={sin,q[WIDTH-1:1]}; cout<=q[0].
- mode 100 rotate left: q<={q[WIDTH-2:0],q[WIDTH-1]}; cout<=q[WIDTH-1].
- mode 101 rotate right: q<={q[0],q[WIDTH-1:1]}; cout<=q[0].
- mode 110 arithmetic shift right: q<={q[WIDTH-1],q[WIDTH-1:1]}; cout<=q[0].
- mode 111 sync clear: q<=RESET_VALUE truncated to WIDTH bits; cout<=0.
- en=0 overrides every mode, including 111.
- Rotates never consult sin. Eight rotates of the same direction restore the original q when WIDTH=8.
- oe is purely combinational on bus_out and has no effect on q, cout or zero.
- No X propagation from sin in modes other than 010/011.
- No internal state other than q and cout.

Test Plan:
- clear=0 with preset=0, clk toggling, en=1, mode=001, d=8'hA5 -> q stays 8'h00 and cout=0 throughout. Release both, next edge -> q=8'hA5.
- preset=0, clear=1 mid-cycle with no clock edge -> q=8'hFF immediately. Release preset and apply mode=000 -> q stays 8'hFF.
- Load 8'h81, mode=010 with sin=0 -> q=8'h02, cout=1. Then mode=011 with sin=1 -> q=8'h81, cout=0.
- Load 8'h96, mode=100 held for 8 edges -> q returns to 8'h96. cout sequence is 1,0,0,1,0,1,1,0.
- Load 8'h90, mode=110 -> q=8'hC8, cout=0. Then en=0 with mode=111 -> q stays 8'hC8. Then en=1 -> q=8'h00 and zero=1.
- oe=0 -> bus_out=8'hZZ while q=8'h3C. oe=1 -> bus_out=8'h3C and qbar=8'hC3.
